anthill_uart_tx_arb: RTL and testbench

Round-robin arbiter and serializer that shares the single anthill UART transmit line (`uart_txd_o`) between several byte-stream requesters, such as the RISC-V firmware console and a hardware debug/trace source. Each requester presents bytes through a valid/ready handshake. A requester can lock the line for a multi-byte packet so that messages from different sources never interleave. The block sits between the requesters and the top-level `uart_txd_o` pin and contains the baud-rate generator and 8N1 framer.

---
 rtl/anthill_uart_tx_arb.sv | 142 ++++++++++++++
 tb/tb_anthill_uart_tx_arb.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anthill_uart_tx_arb.sv
// Round-robin arbiter and 8N1 serializer sharing one UART transmit line between
// several byte-stream requesters. A requester may lock the line for a multi-byte packet.
module anthill_uart_tx_arb #(
    parameter int g_num_req = 2,
    parameter int g_clk_div = 868
) (
    input  logic                   CLK100MHZ,
    input  logic                   resetn,
    input  logic [g_num_req-1:0]   req_valid_i,
    input  logic [8*g_num_req-1:0] req_data_i,
    input  logic [g_num_req-1:0]   req_last_i,
    output logic [g_num_req-1:0]   req_ready_o,
    output logic [g_num_req-1:0]   grant_o,
    output logic                   busy_o,
    output logic                   uart_txd_o
);
    localparam int IW = $clog2(g_num_req);
    localparam int CW = $clog2(g_clk_div);
    localparam logic [CW-1:0]        BAUD_LAST = CW'(g_clk_div - 1);
    localparam logic [IW-1:0]        REQ_LAST  = IW'(g_num_req - 1);
    localparam logic [g_num_req-1:0] ONE_HOT0  = g_num_req'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] lock_owner;
    logic          lock_held;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_byte;

    logic [IW-1:0] sel_idx;
    logic          sel_found;
    logic          hs;
    logic [7:0]    sel_data;
    logic [IW-1:0] rr_next;
    logic          bit_end;
    int            cand;

    // Walk from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        if (lock_held) begin
            sel_found = req_valid_i[lock_owner];
            sel_idx   = lock_owner;
        end else begin
            for (int i = g_num_req - 1; i >= 0; i--) begin
                cand = int'(rr_ptr) + i;
                if (cand >= g_num_req) cand = cand - g_num_req;
                if (req_valid_i[IW'(cand)]) begin
                    sel_found = 1'b1;
                    sel_idx   = IW'(cand);
                end
            end
        end
    end

    // NOTE: ready is combinational, so it is also gated by resetn to read 0 while reset is held.
    assign hs       = resetn && (state == S_IDLE) && sel_found;
    assign sel_data = req_data_i[8*sel_idx +: 8];
    assign rr_next  = (sel_idx == REQ_LAST) ? '0 : sel_idx + IW'(1);
    assign bit_end  = (baud_cnt == BAUD_LAST);

    always_comb begin
        req_ready_o = '0;
        if (hs) req_ready_o[sel_idx] = 1'b1;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!resetn) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            lock_held  <= 1'b0;
            lock_owner <= '0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_byte <= '0;
            grant_o    <= '0;
            busy_o     <= 1'b0;
            uart_txd_o <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        shift_byte <= sel_data;
                        grant_o    <= ONE_HOT0 << sel_idx;
                        busy_o     <= 1'b1;
                        uart_txd_o <= 1'b0;
                        baud_cnt   <= '0;
                        state      <= S_START;
                        if (req_last_i[sel_idx]) begin
                            lock_held <= 1'b0;
                            rr_ptr    <= rr_next;
                        end else begin
                            lock_held  <= 1'b1;
                            lock_owner <= sel_idx;
                        end
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        uart_txd_o <= shift_byte[0];
                        state      <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_txd_o <= 1'b1;
                            state      <= S_STOP;
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            uart_txd_o <= shift_byte[1];
                            shift_byte <= {1'b0, shift_byte[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        busy_o   <= 1'b0;
                        grant_o  <= lock_held ? (ONE_HOT0 << lock_owner) : '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_anthill_uart_tx_arb.sv
// Bench for anthill_uart_tx_arb: directed scenarios with a cycle-level reference model
// of arbitration, lock and frame timing, plus a line decoder scoreboard.
module tb_anthill_uart_tx_arb;
    localparam int N     = 2;
    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;

    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic           busy, txd;

    assign req_valid = {v1, v0};
    assign req_last  = {l1, l0};
    assign req_data  = {d1, d0};

    always #5 clk = ~clk;

    anthill_uart_tx_arb #(.g_num_req(N), .g_clk_div(DIV)) dut (
        .CLK100MHZ  (clk),
        .resetn     (resetn),
        .req_valid_i(req_valid),
        .req_data_i (req_data),
        .req_last_i (req_last),
        .req_ready_o(req_ready),
        .grant_o    (grant),
        .busy_o     (busy),
        .uart_txd_o (txd)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state: arbitration rules and frame timing as plain counters.
    typedef struct {int k; logic [7:0] d; int cyc;} acc_t;
    acc_t       acc_q[$];
    logic [7:0] exp_rx_q[$];
    int         frame_left = 0;
    int         m_rr = 0;
    int         m_owner = 0;
    bit         m_locked = 1'b0;
    logic [N-1:0] m_grant = '0;
    logic [7:0] frame_byte = 8'h00;
    int         cyc = 0;
    int         busy_cnt = 0;

    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_last = 8'h00;
    int         rx_total = 0;

    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        logic         exp_txd;
        logic [7:0]   exp_b;
        int           slot;
        int           k;

        exp_ready = '0;
        if (resetn && frame_left == 0) begin
            if (m_locked) begin
                if (req_valid[m_owner]) exp_ready[m_owner] = 1'b1;
            end else if (req_valid[m_rr]) begin
                exp_ready[m_rr] = 1'b1;
            end else if (req_valid[1 - m_rr]) begin
                exp_ready[1 - m_rr] = 1'b1;
            end
        end
        if (frame_left == 0) begin
            exp_txd = 1'b1;
        end else begin
            slot = (FRAME - frame_left) / DIV;
            if (slot == 0)      exp_txd = 1'b0;
            else if (slot == 9) exp_txd = 1'b1;
            else                exp_txd = frame_byte[slot - 1];
        end

        check("ready", req_ready, exp_ready);
        check("grant", grant, m_grant);
        check("busy", busy, frame_left != 0);
        check("txd", txd, exp_txd);
        check("ready_onehot0", $onehot0(req_ready), 1);
        check("ready_outside_idle", busy & (|req_ready), 0);
        if (busy === 1'b1) busy_cnt++;

        // Line decoder: sample the middle of each bit cell.
        if (!rx_active) begin
            if (txd === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
        end
        if (rx_active) begin
            if (rx_cnt >= DIV + DIV/2 && rx_cnt < 9*DIV && (rx_cnt - DIV/2) % DIV == 0)
                rx_byte[(rx_cnt - DIV/2) / DIV - 1] = txd;
            if (rx_cnt == 9*DIV + DIV/2) begin
                check("rx_stop_bit", txd, 1);
                check("rx_expected_pending", exp_rx_q.size() != 0, 1);
                exp_b = (exp_rx_q.size() != 0) ? exp_rx_q.pop_front() : 8'hxx;
                check("rx_byte_order", rx_byte, exp_b);
                rx_last   = rx_byte;
                rx_total++;
                rx_active = 1'b0;
            end
        end

        cyc++;
        if (!resetn) begin
            frame_left = 0;
            m_rr       = 0;
            m_locked   = 1'b0;
            m_grant    = '0;
            rx_active  = 1'b0;
            exp_rx_q.delete();
        end else if (|exp_ready) begin
            k          = exp_ready[1] ? 1 : 0;
            frame_byte = (k == 1) ? d1 : d0;
            acc_q.push_back('{k, frame_byte, cyc});
            exp_rx_q.push_back(frame_byte);
            frame_left = FRAME;
            m_grant    = '0;
            m_grant[k] = 1'b1;
            if (req_last[k]) begin
                m_locked = 1'b0;
                m_rr     = (k + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_owner  = k;
            end
        end else if (frame_left > 0) begin
            frame_left--;
            if (frame_left == 0) begin
                m_grant = '0;
                if (m_locked) m_grant[m_owner] = 1'b1;
            end
        end
    end

    function automatic logic [7:0] acc_d(input int i);
        if (i < acc_q.size()) return acc_q[i].d;
        return 8'hxx;
    endfunction

    function automatic int acc_c(input int i);
        if (i < acc_q.size()) return acc_q[i].cyc;
        return -1000;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic v, input logic [7:0] d, input logic l);
        if (k == 0) begin v0 = v; d0 = d; l0 = l; end
        else        begin v1 = v; d1 = d; l1 = l; end
    endtask

    // Present one byte and hold it until accepted; call at posedge+1.
    task automatic push_byte(input int k, input logic [7:0] d, input logic l);
        bit done;
        done = 1'b0;
        drive(k, 1'b1, d, l);
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (req_ready[k] === 1'b1) done = 1'b1;
        end
        @(posedge clk);
        #1;
        drive(k, 1'b0, 8'h00, 1'b0);
        check($sformatf("accept_req%0d", k), done, 1);
    endtask

    initial begin
        int base;
        int rx0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_txd", txd, 1);
        check("reset_busy", busy, 0);
        check("reset_grant", grant, 0);
        check("reset_ready", req_ready, 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        tick(2);

        // Single byte 0xA5 from requester 0.
        busy_cnt = 0;
        base = acc_q.size();
        rx0  = rx_total;
        push_byte(0, 8'hA5, 1'b1);
        tick(FRAME + 5);
        check("single_accepted", acc_d(base), 8'hA5);
        check("single_busy_cycles", busy_cnt, FRAME);
        check("single_rx_count", rx_total - rx0, 1);
        check("single_rx_byte", rx_last, 8'hA5);

        // rr_ptr now points at requester 1.
        base = acc_q.size();
        fork
            push_byte(0, 8'h33, 1'b1);
            push_byte(1, 8'h44, 1'b1);
        join
        tick(FRAME + 5);
        check("rr_first", acc_d(base), 8'h44);
        check("rr_second", acc_d(base + 1), 8'h33);

        // Reset in the middle of a locked frame from requester 1.
        push_byte(1, 8'h77, 1'b0);
        tick(15);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_txd", txd, 1);
        check("midreset_busy", busy, 0);
        check("midreset_grant", grant, 0);
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        tick(2);

        // Simultaneous requests after reset: requester 0 first.
        base = acc_q.size();
        fork
            push_byte(0, 8'h11, 1'b1);
            push_byte(1, 8'h22, 1'b1);
        join
        tick(FRAME + 5);
        check("sim_first", acc_d(base), 8'h11);
        check("sim_second", acc_d(base + 1), 8'h22);
        check("sim_spacing", acc_c(base + 1) - acc_c(base), FRAME + 1);

        // Locked 3-byte packet from requester 0 while requester 1 waits.
        base = acc_q.size();
        fork
            begin
                push_byte(0, 8'h01, 1'b0);
                push_byte(0, 8'h02, 1'b0);
                push_byte(0, 8'h03, 1'b1);
            end
            push_byte(1, 8'h55, 1'b1);
        join
        tick(FRAME + 5);
        check("lock_b0", acc_d(base), 8'h01);
        check("lock_b1", acc_d(base + 1), 8'h02);
        check("lock_b2", acc_d(base + 2), 8'h03);
        check("lock_b3", acc_d(base + 3), 8'h55);
        check("lock_spacing", acc_c(base + 1) - acc_c(base), FRAME + 1);
        check("lock_release_spacing", acc_c(base + 3) - acc_c(base + 2), FRAME + 1);

        // Locked owner stalls the line for 200 cycles.
        base = acc_q.size();
        fork
            begin
                push_byte(0, 8'h10, 1'b0);
                tick(200);
                push_byte(0, 8'h20, 1'b1);
            end
            push_byte(1, 8'h66, 1'b1);
        join
        tick(FRAME + 5);
        check("stall_b0", acc_d(base), 8'h10);
        check("stall_b1", acc_d(base + 1), 8'h20);
        check("stall_b2", acc_d(base + 2), 8'h66);
        check("stall_gap", (acc_c(base + 1) - acc_c(base)) >= 200, 1);
        check("rx_drained", exp_rx_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
